seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the calculator's seven-segment display. It shares one set of per-segment combinational decoders across NUM_DIGITS digits. It drives the current 4-bit digit code to the decoders and asserts one active-low digit enable at a time, with an anti-ghosting blank gap between digits. New display values are double-buffered and committed only at a frame boundary, so a digit never tears mid-frame.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
PRESCALE, 50000, clock cycles per digit slot (blank plus show); must exceed BLANK_CYCLES.
BLANK_CYCLES, 16, cycles per slot with all digits off; must be >= 1.

Ports:
JM1222HM_clk  in  1  system clock; all state changes on the rising edge.
JM1222HM_rst_n  in  1  asynchronous, active-low reset.
JM1222HM_en  in  1  display enable; low forces all digits off.
JM1222HM_load  in  1  one-cycle request to update the displayed value.
JM1222HM_data  in  4*NUM_DIGITS  new value; nibble k belongs to digit k, and digit 0 is the least significant.
JM1222HM_load_ack  out  1  one-cycle pulse; the value was captured into the pending buffer.
JM1222HM_digit_out  out  4  code sent to the shared segment decoders.
JM1222HM_blank  out  1  high = decoder outputs gated off.
JM1222HM_an  out  NUM_DIGITS  active-low digit enables, at most one low at a time.
JM1222HM_frame  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state = IDLE, an = all 1, blank = 1, digit_out = 0.
  - load_ack = 0, frame = 0.
  - Display register, pending register, pending flag, digit index and slot counter all cleared to 0.
- Single clock domain. Clock and reset are decided: one clock; reset is asynchronous and active-low.
- IDLE:
  - an = all 1, blank = 1, digit_out = 0.
  - If the pending flag is set, commit pending to the display register and clear the flag.
  - en = 1 moves to BLANK with index 0 and counter 0.
- BLANK:
  - Lasts BLANK_CYCLES cycles; an = all 1, blank = 1.
  - digit_out = display nibble[index], presented early so the decoders settle.
  - Then moves to SHOW.
- SHOW:
  - Lasts PRESCALE-BLANK_CYCLES cycles; an[index] = 0, others 1.
  - blank = 0, digit_out = display nibble[index].
  - At the end of SHOW: index increments and the state moves to BLANK.
  - When index = NUM_DIGITS-1, index wraps to 0 and frame pulses in that same last SHOW cycle.
  - On that wrap, a set pending flag commits pending to display and clears the flag.
- Slot period = PRESCALE cycles; frame period = NUM_DIGITS*PRESCALE cycles. Slot counter width = clog2(PRESCALE).
- Load handshake:
  - load = 1 in any state copies data into pending and sets the flag.
  - load_ack pulses in the following cycle.
  - Back-to-back loads each get their own ack; the last one wins.
  - A load coinciding with a frame-boundary commit is not lost: the old pending commits and the new data stays pending.
- en falling in BLANK or SHOW: next cycle is IDLE, with index and counter cleared; a pending value is kept and committed in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, a digit is suppressed when index != 0, its nibble = 0, and every higher nibble = 0.
  - Suppressed means an stays all 1 and blank = 1.
  - Timing and frame pulses are unchanged.
- Undefined: every digit is lit in its slot regardless of value.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Assert rst_n=0 mid-SHOW (an=4'b1011) -> immediately an=4'b1111, blank=1, digit_out=0, load_ack=0, frame=0, without a clock edge.
2. en=0, load data=16'h1234 -> load_ack=1 next cycle; display commits in IDLE. Raise en -> 2 cycles an=1111/digit_out=4, then 6 cycles an=1110/blank=0/digit_out=4; then digits 3, 2, 1 on an=1101/1011/0111. frame pulses in cycle 32.
3. Showing 16'h1234, load 16'hABCD during digit-1 SHOW -> ack next cycle; digits 2 and 3 still show 2 and 1. After the frame pulse, digit 0 shows D.
4. Load 16'h1111, then 16'h2222 two cycles later within one frame -> two ack pulses; the next frame shows 2 on all digits, never 1.
5. Drop en during digit-2 SHOW -> next cycle an=1111, blank=1. Re-raise en -> scan restarts at digit 0 BLANK.
6. Data 16'h0050 -> with LEADING_ZERO_BLANK_EN, an[3] and an[2] never go low, digit 1 shows 5, digit 0 shows 0. Without the macro, all four digits light (0, 0, 5, 0).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blank gaps and frame-boundary value commit.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always lit).
//   state | meaning
//   IDLE  | display off, pending value committed
//   BLANK | all digits off, next digit code presented to the decoders
//   SHOW  | current digit enabled
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    JM1222HM_clk,
    input  logic                    JM1222HM_rst_n,
    input  logic                    JM1222HM_en,
    input  logic                    JM1222HM_load,
    input  logic [4*NUM_DIGITS-1:0] JM1222HM_data,
    output logic                    JM1222HM_load_ack,
    output logic [3:0]              JM1222HM_digit_out,
    output logic                    JM1222HM_blank,
    output logic [NUM_DIGITS-1:0]   JM1222HM_an,
    output logic                    JM1222HM_frame
);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           disp_q, disp_d;
    logic [DW-1:0]           pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    commit;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    blank_q, blank_d;
    logic [3:0]              digit_q, digit_d;
    logic                    ack_q;
    logic                    frame_q, frame_d;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic lead_zero(input logic [DW-1:0] v, input logic [IDX_W-1:0] idx);
        logic z;
        z = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && v[4*k +: 4] != 4'h0) z = 1'b0;
        end
        return z && (idx != '0);
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                commit = pend_vld_q;
                if (JM1222HM_en) begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (!JM1222HM_en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
            end
            SHOW: begin
                if (!JM1222HM_en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        commit = pend_vld_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // commit takes the old pending value, so a coincident load stays pending
        if (commit) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        if (JM1222HM_load) begin
            pend_d     = JM1222HM_data;
            pend_vld_d = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        lit = (state_d == SHOW) && !lead_zero(disp_d, idx_d);
`else
        lit = (state_d == SHOW);
`endif
        an_d    = lit ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        blank_d = !lit;
        digit_d = (state_d == IDLE) ? 4'h0 : disp_d[{idx_d, 2'b00} +: 4];
        frame_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == SLOT_LAST);
    end

    always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
        if (!JM1222HM_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= '1;
            blank_q    <= 1'b1;
            digit_q    <= 4'h0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            blank_q    <= blank_d;
            digit_q    <= digit_d;
            ack_q      <= JM1222HM_load;
            frame_q    <= frame_d;
        end
    end

    assign JM1222HM_load_ack  = ack_q;
    assign JM1222HM_digit_out = digit_q;
    assign JM1222HM_blank     = blank_q;
    assign JM1222HM_an        = an_q;
    assign JM1222HM_frame     = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl; the reference model works on a scan timeline
// (cycle offset within the frame) rather than on explicit states.
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;
    localparam int FRAME = N * P;

    logic           clk, rst_n, en, load;
    logic [4*N-1:0] data;
    logic           load_ack, blank, frame;
    logic [3:0]     digit_out;
    logic [N-1:0]   an;

    seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .JM1222HM_clk      (clk),
        .JM1222HM_rst_n    (rst_n),
        .JM1222HM_en       (en),
        .JM1222HM_load     (load),
        .JM1222HM_data     (data),
        .JM1222HM_load_ack (load_ack),
        .JM1222HM_digit_out(digit_out),
        .JM1222HM_blank    (blank),
        .JM1222HM_an       (an),
        .JM1222HM_frame    (frame)
    );

    typedef struct packed {
        logic [N-1:0] an;
        logic         blank;
        logic [3:0]   dig;
        logic         frame;
        logic         ack;
    } obs_t;

    obs_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model: scan position, displayed value, pending value
    logic [4*N-1:0] m_disp, m_pend;
    bit             m_pv, m_act;
    int             m_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic compare(input string name, input obs_t got, input obs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got an=%b blank=%b digit=%h frame=%b ack=%b, want an=%b blank=%b digit=%h frame=%b ack=%b",
                     name, $time, got.an, got.blank, got.dig, got.frame, got.ack,
                     want.an, want.blank, want.dig, want.frame, want.ack);
        end
    endtask

    function automatic obs_t model_out(input bit ack);
        obs_t x;
        int d, ph;
        bit lit;
        x = {{N{1'b1}}, 1'b1, 4'h0, 1'b0, ack};
        if (m_act) begin
            d   = (m_t / P) % N;
            ph  = m_t % P;
            x.dig = m_disp[4*d +: 4];
            lit = (ph >= B);
`ifdef LEADING_ZERO_BLANK_EN
            if (d != 0 && (m_disp >> (4*d)) == 0) lit = 1'b0;
`endif
            if (lit) begin
                x.an    = ~(N'(1) << d);
                x.blank = 1'b0;
            end
            x.frame = (m_t == FRAME - 1);
        end
        return x;
    endfunction

    task automatic drive(input logic e, input logic l, input logic [4*N-1:0] d);
        @(negedge clk);
        en = e; load = l; data = d;
        if (m_act) begin
            if (!e) begin
                m_act = 1'b0;
                m_t   = 0;
            end else begin
                if (m_t == FRAME - 1 && m_pv) begin
                    m_disp = m_pend;
                    m_pv   = 1'b0;
                end
                m_t = (m_t + 1) % FRAME;
            end
        end else begin
            if (m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (e) begin
                m_act = 1'b1;
                m_t   = 0;
            end
        end
        if (l) begin
            m_pend = d;
            m_pv   = 1'b1;
        end
        q.push_back(model_out(l));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0);
    endtask

    task automatic run_until_t(input int tgt);
        int n;
        n = 0;
        while (!(m_act && m_t == tgt)) begin
            if (n == 4 * FRAME) begin
                vectors++;
                miscompares++;
                $display("FAIL run_until: scan position %0d not reached, model at %0d", tgt, m_t);
                return;
            end
            drive(1'b1, 1'b0, '0);
            n++;
        end
    endtask

    // monitor: one expected observation per clock edge that the driver scheduled
    initial begin
        obs_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                compare("scan", {an, blank, digit_out, frame, load_ack}, x);
            end
        end
    end

    initial begin
        obs_t rst_obs;
        logic [4*N-1:0] rd;
        rst_obs = {{N{1'b1}}, 1'b1, 4'h0, 1'b0, 1'b0};
        en = 1'b0; load = 1'b0; data = '0;
        m_disp = '0; m_pend = '0; m_pv = 1'b0; m_act = 1'b0; m_t = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 compare("reset_init", {an, blank, digit_out, frame, load_ack}, rst_obs);
        @(negedge clk);
        rst_n = 1'b1;

        // load while disabled, commit in idle, then one full frame
        drive(1'b0, 1'b1, 16'h1234);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        run(FRAME + 4);

        // load mid-frame during digit 1 show
        run_until_t(1 * P + B);
        drive(1'b1, 1'b1, 16'hABCD);
        run(FRAME + 8);

        // back-to-back loads in one frame, last wins
        run_until_t(B);
        drive(1'b1, 1'b1, 16'h1111);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 16'h2222);
        run(2 * FRAME);

        // load coincides with the frame-boundary commit
        run_until_t(P);
        drive(1'b1, 1'b1, 16'h5A5A);
        run_until_t(FRAME - 1);
        drive(1'b1, 1'b1, 16'h0F0F);
        run(2 * FRAME);

        // drop enable during digit 2 show, then restart
        run_until_t(2 * P + B + 1);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        run(FRAME + 4);

        // leading-zero pattern
        drive(1'b0, 1'b1, 16'h0050);
        drive(1'b0, 1'b0, '0);
        run(FRAME + 4);
        drive(1'b0, 1'b1, 16'h0000);
        drive(1'b0, 1'b0, '0);
        run(FRAME + 4);

        // randomized traffic
        for (int i = 0; i < 900; i++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rd = rd >> (4 * $urandom_range(1, 4));
            drive(($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, rd);
        end

        // asynchronous reset in the middle of digit 2 show
        run_until_t(2 * P + B + 2);
        @(posedge clk);
        #3;
        en = 1'b0; load = 1'b0;
        rst_n = 1'b0;
        #1 compare("reset_async", {an, blank, digit_out, frame, load_ack}, rst_obs);
        m_disp = '0; m_pend = '0; m_pv = 1'b0; m_act = 1'b0; m_t = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'h9876);
        drive(1'b0, 1'b0, '0);
        run(FRAME + 2);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected observations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
